// File: rtl/perip_pkg.sv
// rtl/perip_pkg.sv - peripheral bridge address map, access encodings and write-lane helpers
package perip_pkg;

  localparam logic [31:0] DRAM_BASE = 32'h8010_0000;
  localparam logic [31:0] SW_ADDR   = 32'h8020_0000;
  localparam logic [31:0] KEY_ADDR  = 32'h8020_0010;
  localparam logic [31:0] SEG_ADDR  = 32'h8020_0020;
  localparam logic [31:0] LED_ADDR  = 32'h8020_0040;
  localparam logic [31:0] CNT_ADDR  = 32'h8020_0050;

  localparam logic [1:0] MASK_B = 2'b00;
  localparam logic [1:0] MASK_H = 2'b01;
  localparam logic [1:0] MASK_W = 2'b11;

  localparam logic [31:0] CNT_START = 32'h8000_0000;
  localparam logic [31:0] CNT_STOP  = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [3:0]  be;
    logic [31:0] data;
  } wr_lanes_t;

  // Store data is replicated across lanes so every enabled lane sees its bytes;
  // misaligned halves/words produce an all-zero enable and are dropped.
  function automatic wr_lanes_t lane_write(input logic [1:0] mask, input logic [1:0] off,
                                           input logic [31:0] wdata);
    wr_lanes_t r;
    r.be   = 4'b0000;
    r.data = 32'h0;
    case (mask)
      MASK_B: begin
        r.be   = 4'b0001 << off;
        r.data = {4{wdata[7:0]}};
      end
      MASK_H: begin
        if (!off[0]) begin
          r.be   = off[1] ? 4'b1100 : 4'b0011;
          r.data = {2{wdata[15:0]}};
        end
      end
      default: begin
        if (off == 2'b00) begin
          r.be   = 4'b1111;
          r.data = wdata;
        end
      end
    endcase
    return r;
  endfunction

  function automatic logic [31:0] apply_be(input logic [31:0] old, input logic [3:0] be,
                                           input logic [31:0] data);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = data[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/perip_dram.sv
// rtl/perip_dram.sv - data RAM with asynchronous read and per-byte synchronous write
module perip_dram #(
  parameter int WORDS = 16384,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/perip_bridge.sv
// rtl/perip_bridge.sv - CPU peripheral bus responder: DRAM, switches, keys, LEDs, 7-seg and counter
module perip_bridge
  import perip_pkg::*;
#(
  parameter int DRAM_WORDS = 16384,
  parameter int CNT_DIV    = 50000
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic [31:0] perip_addr,
  input  logic        perip_wen,
  input  logic [1:0]  perip_mask,
  input  logic [31:0] perip_wdata,
  output logic [31:0] perip_rdata,
  input  logic [15:0] sw,
  input  logic [4:0]  key,
  output logic [15:0] led,
  output logic [31:0] seg_data
);

  localparam int          AW         = $clog2(DRAM_WORDS);
  localparam logic [31:0] DRAM_BYTES = 32'(4 * DRAM_WORDS);
  localparam logic [31:0] PRE_MAX    = 32'(CNT_DIV - 1);

  logic [31:0] dram_off, dram_rdata;
  logic        dram_hit, sw_hit, key_hit, seg_hit, led_hit, cnt_hit;
  logic        wr_ok, cnt_start, cnt_stop;
  wr_lanes_t   lanes;

  logic [15:0] sw_s1, sw_s2;
  logic [4:0]  key_s1, key_s2;
  logic [15:0] led_q;
  logic [31:0] seg_q;
  logic        run;
  logic [31:0] pre, count;

  assign dram_off = perip_addr - DRAM_BASE;
  assign dram_hit = (perip_addr >= DRAM_BASE) && (dram_off < DRAM_BYTES);
  assign sw_hit   = perip_addr[31:2] == SW_ADDR[31:2];
  assign key_hit  = perip_addr[31:2] == KEY_ADDR[31:2];
  assign seg_hit  = perip_addr[31:2] == SEG_ADDR[31:2];
  assign led_hit  = perip_addr[31:2] == LED_ADDR[31:2];
  assign cnt_hit  = perip_addr[31:2] == CNT_ADDR[31:2];

  assign lanes = lane_write(perip_mask, perip_addr[1:0], perip_wdata);
  assign wr_ok = perip_wen && !cpu_rst;

  // Counter commands are only recognised as complete aligned word stores.
  assign cnt_start = wr_ok && cnt_hit && (lanes.be == 4'hF) && (lanes.data == CNT_START);
  assign cnt_stop  = wr_ok && cnt_hit && (lanes.be == 4'hF) && (lanes.data == CNT_STOP);

  perip_dram #(.WORDS(DRAM_WORDS), .AW(AW)) u_dram (
    .clk   (cpu_clk),
    .we    (wr_ok && dram_hit),
    .addr  (dram_off[AW+1:2]),
    .be    (lanes.be),
    .wdata (lanes.data),
    .rdata (dram_rdata)
  );

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      key_s1 <= '0;
      key_s2 <= '0;
      led_q  <= '0;
      seg_q  <= '0;
    end else begin
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
      key_s1 <= key;
      key_s2 <= key_s1;
      if (perip_wen && led_hit) begin
        if (lanes.be[0]) led_q[7:0]  <= lanes.data[7:0];
        if (lanes.be[1]) led_q[15:8] <= lanes.data[15:8];
      end
      if (perip_wen && seg_hit) seg_q <= apply_be(seg_q, lanes.be, lanes.data);
    end
  end

  // A start write overrides any tick landing on the same edge; stop likewise freezes count.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      run   <= 1'b0;
      pre   <= '0;
      count <= '0;
    end else if (cnt_start) begin
      run   <= 1'b1;
      pre   <= '0;
      count <= '0;
    end else if (cnt_stop) begin
      run <= 1'b0;
    end else if (run) begin
      if (pre == PRE_MAX) begin
        pre   <= '0;
        count <= count + 32'd1;
      end else begin
        pre <= pre + 32'd1;
      end
    end
  end

  always_comb begin
    perip_rdata = 32'h0;
    if (dram_hit)     perip_rdata = dram_rdata;
    else if (sw_hit)  perip_rdata = {16'h0, sw_s2};
    else if (key_hit) perip_rdata = {27'h0, key_s2};
    else if (seg_hit) perip_rdata = seg_q;
    else if (led_hit) perip_rdata = {16'h0, led_q};
    else if (cnt_hit) perip_rdata = count;
  end

  assign led      = led_q;
  assign seg_data = seg_q;

endmodule

// File: tb/tb_perip_bridge.sv
// tb/tb_perip_bridge.sv - self-checking bench for perip_bridge
module tb_perip_bridge;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic [31:0] perip_addr;
  logic        perip_wen;
  logic [1:0]  perip_mask;
  logic [31:0] perip_wdata;
  logic [31:0] perip_rdata;
  logic [15:0] sw;
  logic [4:0]  key;
  logic [15:0] led;
  logic [31:0] seg_data;

  int checks = 0;
  int errors = 0;

  perip_bridge #(.DRAM_WORDS(1024), .CNT_DIV(4)) dut (
    .cpu_clk     (cpu_clk),
    .cpu_rst     (cpu_rst),
    .perip_addr  (perip_addr),
    .perip_wen   (perip_wen),
    .perip_mask  (perip_mask),
    .perip_wdata (perip_wdata),
    .perip_rdata (perip_rdata),
    .sw          (sw),
    .key         (key),
    .led         (led),
    .seg_data    (seg_data)
  );

  always #5 cpu_clk = ~cpu_clk;

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [1:0]  mask;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [$];

  // Byte-level model: 8 DRAM words from 0x8010_0100 followed by the SEG word.
  logic [7:0] mdl [36];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [1:0] m, input logic [31:0] d);
    perip_addr = a; perip_mask = m; perip_wdata = d; perip_wen = 1'b1;
    tick();
    perip_wen = 1'b0;
  endtask

  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    perip_addr = a; perip_wen = 1'b0;
    #1;
    check(name, perip_rdata, exp);
  endtask

  function automatic int mdl_base(input logic [31:0] a);
    if (a >= 32'h8010_0100 && a < 32'h8010_0120) return int'(a - 32'h8010_0100);
    if (a >= 32'h8020_0020 && a < 32'h8020_0024) return 32 + int'(a - 32'h8020_0020);
    return -1;
  endfunction

  task automatic mdl_write(input logic [31:0] a, input logic [1:0] m, input logic [31:0] d);
    int b;
    b = mdl_base(a);
    if (b < 0) return;
    if (m == 2'b00) begin
      mdl[b] = d[7:0];
    end else if (m == 2'b01) begin
      if (a % 2 == 0) begin mdl[b] = d[7:0]; mdl[b+1] = d[15:8]; end
    end else if (a % 4 == 0) begin
      for (int i = 0; i < 4; i++) mdl[b+i] = d[8*i +: 8];
    end
  endtask

  function automatic logic [31:0] mdl_read(input logic [31:0] a);
    int b;
    b = mdl_base({a[31:2], 2'b00});
    if (b < 0) return 32'h0;
    return {mdl[b+3], mdl[b+2], mdl[b+1], mdl[b]};
  endfunction

  initial begin
    cpu_rst = 1'b1; perip_addr = 32'h0; perip_wen = 1'b0; perip_mask = 2'b11;
    perip_wdata = 32'h0; sw = 16'h0; key = 5'h0;
    tick(); tick();
    check("reset_led", {16'h0, led}, 32'h0);
    check("reset_seg", seg_data, 32'h0);
    rd("reset_cnt", 32'h8020_0050, 32'h0);
    rd("reset_sw", 32'h8020_0000, 32'h0);
    cpu_rst = 1'b0;
    tick();

    vecs.push_back('{32'h8010_0004, 1'b1, 2'b11, 32'h1122_3344, 32'h1122_3344});
    vecs.push_back('{32'h8010_0005, 1'b1, 2'b00, 32'h0000_00AA, 32'h1122_AA44});
    vecs.push_back('{32'h8010_0006, 1'b1, 2'b01, 32'h0000_BEEF, 32'hBEEF_AA44});
    vecs.push_back('{32'h8010_0000, 1'b1, 2'b11, 32'h0102_0304, 32'h0102_0304});
    vecs.push_back('{32'h8010_0001, 1'b1, 2'b01, 32'h0000_5555, 32'h0102_0304});
    vecs.push_back('{32'h8010_0002, 1'b1, 2'b11, 32'h7777_7777, 32'h0102_0304});
    vecs.push_back('{32'h8030_0000, 1'b0, 2'b11, 32'h0,         32'h0});
    vecs.push_back('{32'h8030_0000, 1'b1, 2'b11, 32'h1234_5678, 32'h0});
    vecs.push_back('{32'h8020_0040, 1'b1, 2'b11, 32'h0000_A5A5, 32'h0000_A5A5});
    vecs.push_back('{32'h8020_0041, 1'b1, 2'b00, 32'h0000_003C, 32'h0000_3CA5});
    vecs.push_back('{32'h8020_0022, 1'b1, 2'b01, 32'h0000_1234, 32'h1234_0000});
    vecs.push_back('{32'h8020_0000, 1'b1, 2'b11, 32'hFFFF_FFFF, 32'h0});
    vecs.push_back('{32'h8010_0008, 1'b1, 2'b10, 32'hCAFE_F00D, 32'hCAFE_F00D});
    foreach (vecs[i]) begin
      if (vecs[i].wen) wr(vecs[i].addr, vecs[i].mask, vecs[i].wdata);
      rd($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
    end
    check("led_port", {16'h0, led}, 32'h0000_3CA5);
    check("seg_port", seg_data, 32'h1234_0000);

    // Reset with a write pending: registers clear and the write is dropped.
    cpu_rst = 1'b1;
    perip_addr = 32'h8020_0040; perip_mask = 2'b11; perip_wdata = 32'h0000_FFFF; perip_wen = 1'b1;
    tick();
    cpu_rst = 1'b0; perip_wen = 1'b0;
    check("rst_led", {16'h0, led}, 32'h0);
    check("rst_seg", seg_data, 32'h0);

    // Synchronizer latency.
    sw = 16'h1234;
    rd("sw_c0", 32'h8020_0000, 32'h0);
    tick(); rd("sw_c1", 32'h8020_0000, 32'h0);
    tick(); rd("sw_c2", 32'h8020_0000, 32'h0000_1234);
    key = 5'b10001;
    tick(); rd("key_c1", 32'h8020_0010, 32'h0);
    tick(); rd("key_c2", 32'h8020_0010, 32'h0000_0011);

    // Counter with CNT_DIV=4.
    wr(32'h8020_0050, 2'b11, 32'h8000_0000);
    repeat (40) tick();
    rd("cnt_run40", 32'h8020_0050, 32'd10);
    wr(32'h8020_0050, 2'b11, 32'hFFFF_FFFF);
    repeat (20) tick();
    rd("cnt_stop", 32'h8020_0050, 32'd10);
    wr(32'h8020_0050, 2'b11, 32'h1234_5678);
    repeat (8) tick();
    rd("cnt_ignore", 32'h8020_0050, 32'd10);
    wr(32'h8020_0050, 2'b11, 32'h8000_0000);
    rd("cnt_restart", 32'h8020_0050, 32'd0);
    repeat (3) tick();
    wr(32'h8020_0050, 2'b11, 32'h8000_0000);
    rd("cnt_start_wins", 32'h8020_0050, 32'd0);
    repeat (4) tick();
    rd("cnt_after_start", 32'h8020_0050, 32'd1);
    cpu_rst = 1'b1; tick(); cpu_rst = 1'b0;
    rd("cnt_reset", 32'h8020_0050, 32'd0);
    repeat (8) tick();
    rd("cnt_halted", 32'h8020_0050, 32'd0);

    // Same-cycle write then read of one DRAM word.
    wr(32'h8010_0010, 2'b11, 32'h0BAD_F00D);
    perip_addr = 32'h8010_0010; perip_mask = 2'b11; perip_wdata = 32'hDEAD_BEEF; perip_wen = 1'b1;
    #1 check("same_cycle_old", perip_rdata, 32'h0BAD_F00D);
    tick();
    perip_wen = 1'b0;
    rd("same_cycle_new", 32'h8010_0010, 32'hDEAD_BEEF);

    // Randomized byte/half/word traffic against the byte-level model.
    for (int w = 0; w < 9; w++) begin
      logic [31:0] a, d;
      a = (w < 8) ? 32'h8010_0100 + 32'(4 * w) : 32'h8020_0020;
      d = $urandom;
      wr(a, 2'b11, d);
      mdl_write(a, 2'b11, d);
    end
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a, d;
      logic [1:0]  m;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 8)       a = 32'h8010_0100 + 32'($urandom_range(0, 31));
      else if (sel == 8) a = 32'h8020_0020 + 32'($urandom_range(0, 3));
      else               a = 32'h8030_0000 + 32'($urandom_range(0, 15));
      m = 2'($urandom_range(0, 3));
      d = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        wr(a, m, d);
        mdl_write(a, m, d);
      end
      a = 32'h8010_0100 + 32'(4 * $urandom_range(0, 7));
      if ($urandom_range(0, 4) == 0) a = 32'h8020_0020;
      rd($sformatf("rand%0d", n), a, mdl_read(a));
    end
    check("rand_seg_port", seg_data, mdl_read(32'h8020_0020));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/perip_bridge.md
Name: perip_bridge

Overview:
Responder end of the CPU peripheral bus. It decodes perip_addr, performs byte-lane-correct writes for perip_mask, and returns the raw aligned word on perip_rdata. It holds the data RAM and the memory-mapped I/O registers (switches, keys, LEDs, 7-seg, counter). It sits beside myCPU in the SoC top; the CPU does sign/zero extension and lane selection on reads.

Parameters:
DRAM_WORDS, 16384, data RAM depth in 32-bit words (power of 2)
CNT_DIV, 50000, cpu_clk cycles per counter tick (≥1)

Ports:
cpu_clk  input  1  system clock; all state updates on rising edge
cpu_rst  input  1  synchronous, active-high reset
perip_addr  input  32  byte address from CPU
perip_wen  input  1  write enable, one write per cycle when high
perip_mask  input  2  access size: 00 byte, 01 half, 11 word
perip_wdata  input  32  store data, unshifted (byte in [7:0], half in [15:0])
perip_rdata  output  32  raw aligned word at perip_addr[31:2], combinational
sw  input  16  board switches, asynchronous
key  input  5  board keys, asynchronous
led  output  16  LED register
seg_data  output  32  7-seg display word (8 hex digits)

Behaviour:
- Address map (word-aligned decode on addr[31:2]):
  - DRAM 0x8010_0000 .. +4*DRAM_WORDS-1: RW.
  - SW 0x8020_0000: RO, {16'b0, sw_sync}.
  - KEY 0x8020_0010: RO, {27'b0, key_sync}.
  - SEG 0x8020_0020: RW.
  - LED 0x8020_0040: RW, low 16 bits.
  - CNT 0x8020_0050: RW (see counter).
- Reads are combinational, zero-latency: same-cycle perip_rdata for the current perip_addr (single-cycle CPU). A read of an address written in the same cycle returns the old value; the new value is visible from the next cycle.
- Unmapped read → 0x0000_0000. Unmapped write → ignored.
- Writes commit at the rising edge when perip_wen=1:
  - mask 00: wdata[7:0] → byte lane addr[1:0].
  - mask 01: wdata[15:0] → half addr[1]. If addr[0]=1 the write is ignored.
  - mask 11: full word. If addr[1:0]≠0 the write is ignored.
  - mask 10: treated as 11.
- Sub-word writes to I/O registers are allowed and merge into the addressed lanes only. Writes to SW/KEY are ignored.
- sw and key each pass through a 2-flop synchronizer. Register reads show inputs 2 cycles after they change.
- Counter:
  - State: RUN flag, 32-bit prescaler pre, 32-bit count.
  - When RUN=1: pre increments each cycle. When pre==CNT_DIV-1, pre→0 and count+1, wrapping 0xFFFF_FFFF→0.
  - Write word 0x8000_0000 to CNT: RUN=1, pre=0, count=0 (restart).
  - Write 0xFFFF_FFFF to CNT: RUN=0, count held.
  - Any other write value to CNT is ignored.
  - Read CNT returns count.
  - A tick coinciding with a start write: the start wins.
- Reset (cpu_rst=1 at edge): led=0, seg_data=0, RUN=0, pre=0, count=0, synchronizers=0. DRAM contents are not reset (initialised from file in simulation). Reset mid-count aborts counting immediately; perip_wen is ignored during reset.
- perip_rdata during reset follows the decode using the reset register values.

Decomposition:
- Package perip_pkg:
  - Base/offset address localparams (DRAM_BASE, SW_ADDR, KEY_ADDR, SEG_ADDR, LED_ADDR, CNT_ADDR).
  - Mask encodings MASK_B/MASK_H/MASK_W.
  - CNT_START/CNT_STOP constants.
  - Function computing the 4-bit byte-enable and lane-shifted write word from (mask, addr[1:0], wdata).
- Sub-module perip_dram: byte-enable RAM with asynchronous read and synchronous 4-lane write. The bridge keeps decode, I/O registers and the counter.

Test Plan:
- SW 0x11223344 @0x8010_0004, then SB 0xAA @0x8010_0005 → read returns 0x1122AA44. SH 0xBEEF @0x8010_0006 → 0xBEEFAA44.
- SH @0x8010_0001 and SW @0x8010_0002 with wen=1 → word unchanged. Read of 0x8030_0000 → 0x0.
- SW 0x0000_A5A5 to LED → led=0xA5A5 next cycle. SB 0x3C @0x8020_0041 → led=0x3CA5. Assert cpu_rst for 1 cycle → led=0, seg_data=0.
- sw=0x1234 applied → SW read returns 0x0 for cycles 0–1, 0x0000_1234 from cycle 2. key=5'b10001 → KEY read 0x11 after 2 cycles.
- CNT_DIV=4: write CNT_START, run 40 cycles → count=10. Write CNT_STOP, wait 20 cycles → count still 10. Write CNT_START → count=0. Reset mid-run → count=0, RUN=0.
- Same-cycle SW 0xDEADBEEF and read at same DRAM address → rdata shows old value that cycle, 0xDEADBEEF next cycle.
